// File: rtl/linear_led_stream_pkg.sv
// linear_led_stream_pkg: shared types for the LED pixel stream block
//   rgb_t       - 24-bit colour, R in [23:16], G in [15:8], B in [7:0]
//   lls_state_t - stream FSM states
//   idx_w()     - index width for an n-entry table, never below 1
package linear_led_stream_pkg;

    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {IDLE, PREFIX, STREAM} lls_state_t;

    localparam rgb_t BLACK = '0;

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/linear_led_stream_slot_bin_lookup.sv
// slot_bin_lookup: maps an LED slot to the lowest bin whose prefix sum exceeds it
//   slot - LED slot index
//   pre  - saturated, non-decreasing prefix sums of the bin counts
//   bin  - owning bin (0 when pad)
//   pad  - slot lies beyond the last prefix sum, so it is black
module slot_bin_lookup #(
    parameter int BIN_QTY = 12,
    parameter int CW      = 6,
    parameter int BW      = 4
) (
    input  logic [CW-1:0]               slot,
    input  logic [BIN_QTY-1:0][CW-1:0]  pre,
    output logic [BW-1:0]               bin,
    output logic                        pad
);

    // Scan high to low so the lowest matching bin is the one left standing.
    always_comb begin
        bin = '0;
        pad = 1'b1;
        for (int i = BIN_QTY - 1; i >= 0; i--) begin
            if (slot < pre[i]) begin
                bin = BW'(i);
                pad = 1'b0;
            end
        end
    end

endmodule

// File: rtl/linear_led_stream.sv
// linear_led_stream: serialises one frame of per-bin colours/counts into a per-LED RGB stream
//   clk, rst               - clock, synchronous active-high reset
//   in_valid/in_ready      - frame handshake
//   in_rgb                 - per-bin colour, bin 0 in LSBs
//   in_counts              - per-bin LED count, bin 0 in LSBs
//   cfg_reverse            - emit slots in reverse order (latched per frame)
//   cfg_rotate             - advance the slot offset after each frame (latched per frame)
//   out_valid/out_ready    - pixel handshake
//   out_rgb, out_last      - pixel colour, high on pixel LEDS-1
//   frame_done             - one-cycle pulse after the final pixel handshake
module linear_led_stream
    import linear_led_stream_pkg::*;
#(
    parameter int LEDS     = 50,
    parameter int BIN_QTY  = 12,
    parameter int CW       = $clog2(LEDS + 1),
    parameter int ROT_STEP = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_QTY*24-1:0]   in_rgb,
    input  logic [BIN_QTY*CW-1:0]   in_counts,
    input  logic                    cfg_reverse,
    input  logic                    cfg_rotate,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [23:0]             out_rgb,
    output logic                    out_last,
    output logic                    frame_done
);

    localparam int          BW     = idx_w(BIN_QTY);
    localparam logic [CW:0] LEDS_W = (CW+1)'(LEDS);
    localparam logic [CW-1:0] LEDS_C = CW'(LEDS);

    lls_state_t                 state;
    rgb_t [BIN_QTY-1:0]         rgb_q;
    logic [BIN_QTY-1:0][CW-1:0] cnt_q;
    logic [BIN_QTY-1:0][CW-1:0] pre_q;
    logic [CW-1:0]              acc;
    logic [CW-1:0]              offset;
    logic [CW-1:0]              nk;
    logic [CW-1:0]              slot_r;
    logic [BW-1:0]              bidx;
    logic                       rev_q;
    logic                       rot_q;
    logic                       slot_ok;
    logic [BW-1:0]              lk_bin;
    logic                       lk_pad;
    logic [CW:0]                pre_sum;
    logic [CW-1:0]              pre_sat;
    logic [CW:0]                rot_sum;
    logic [CW-1:0]              rot_next;
    logic                       more;

    // Slot of pixel j; one conditional subtract is enough since both terms are < LEDS.
    function automatic logic [CW-1:0] slot_of(input logic [CW-1:0] j);
        logic [CW:0] t;
        t = rev_q ? LEDS_W - (CW+1)'(1) - {1'b0, j} + {1'b0, offset}
                  : {1'b0, j} + {1'b0, offset};
        return t >= LEDS_W ? CW'(t - LEDS_W) : t[CW-1:0];
    endfunction

    assign pre_sum  = {1'b0, acc} + {1'b0, cnt_q[bidx]};
    assign pre_sat  = pre_sum > LEDS_W ? LEDS_C : pre_sum[CW-1:0];
    assign rot_sum  = {1'b0, offset} + (CW+1)'(ROT_STEP);
    assign rot_next = rot_sum >= LEDS_W ? CW'(rot_sum - LEDS_W) : rot_sum[CW-1:0];
    assign more     = nk != LEDS_C;

    slot_bin_lookup #(
        .BIN_QTY (BIN_QTY),
        .CW      (CW),
        .BW      (BW)
    ) u_lookup (
        .slot (slot_r),
        .pre  (pre_q),
        .bin  (lk_bin),
        .pad  (lk_pad)
    );

    // slot_r always holds the slot of pixel nk, the next pixel to be presented;
    // the first STREAM cycle only primes it so the lookup never sits behind the
    // offset adder in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_rgb    <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            offset     <= '0;
            rgb_q      <= '0;
            cnt_q      <= '0;
            pre_q      <= '0;
            acc        <= '0;
            bidx       <= '0;
            nk         <= '0;
            slot_r     <= '0;
            slot_ok    <= 1'b0;
            rev_q      <= 1'b0;
            rot_q      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        rgb_q    <= in_rgb;
                        cnt_q    <= in_counts;
                        rev_q    <= cfg_reverse;
                        rot_q    <= cfg_rotate;
                        acc      <= '0;
                        bidx     <= '0;
                        in_ready <= 1'b0;
                        state    <= PREFIX;
                    end
                end
                PREFIX: begin
                    pre_q[bidx] <= pre_sat;
                    acc         <= pre_sat;
                    bidx        <= bidx + BW'(1);
                    if (bidx == BW'(BIN_QTY - 1)) begin
                        nk      <= '0;
                        slot_ok <= 1'b0;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (!slot_ok) begin
                        slot_r  <= slot_of(nk);
                        slot_ok <= 1'b1;
                    end else if (more && (!out_valid || out_ready)) begin
                        out_rgb   <= lk_pad ? BLACK : rgb_q[lk_bin];
                        out_last  <= nk == LEDS_C - CW'(1);
                        out_valid <= 1'b1;
                        nk        <= nk + CW'(1);
                        slot_r    <= slot_of(nk + CW'(1));
                    end else if (out_valid && out_ready) begin
                        out_valid  <= 1'b0;
                        out_last   <= 1'b0;
                        frame_done <= 1'b1;
                        in_ready   <= 1'b1;
                        offset     <= rot_q ? rot_next : offset;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/linear_led_stream.md
Name: linear_led_stream

Overview:
- Successor stage to the linear visualizer top. Consumes one frame of per-bin colours plus per-bin LED counts and serialises it into an ordered per-LED RGB pixel stream with valid/ready flow control.
- Generalises LED count, bin count and count width.
- Adds behaviour the visualizer lacks: frame handshake with back-pressure, count overflow/underflow handling, optional reverse direction, and a per-frame rotation offset.
- Sits between the visualizer and the LED serial driver.

Parameters:
- LEDS, 50, number of physical LEDs (must be ≥2).
- BIN_QTY, 12, number of note bins per frame.
- CW, $clog2(LEDS+1), width of each bin LED count and of the prefix sums.
- ROT_STEP, 1, slots the offset advances per completed frame when rotation is enabled (0 ≤ ROT_STEP < LEDS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  frame presented
- in_ready  out  1  block can accept a frame
- in_rgb  in  BIN_QTY*24  per-bin colour {R,G,B}, bin 0 in LSBs
- in_counts  in  BIN_QTY*CW  per-bin LED count
- cfg_reverse  in  1  emit pixels in reverse slot order
- cfg_rotate  in  1  enable per-frame offset advance
- out_valid  out  1  pixel valid
- out_ready  in  1  downstream accepts pixel
- out_rgb  out  24  pixel colour
- out_last  out  1  high with final pixel (index LEDS-1) of the frame
- frame_done  out  1  one-cycle pulse after the last pixel handshake

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, out_rgb=0, out_last=0, frame_done=0, offset=0. All latched frame data cleared to 0.
- FSM states: IDLE, PREFIX, STREAM.

IDLE:
- in_ready=1.
- On in_valid&in_ready: latch in_rgb, in_counts, cfg_reverse and cfg_rotate (frame-stable; later cfg changes are ignored until the next frame). Go to PREFIX; in_ready=0 from the next cycle.

PREFIX:
- One bin per cycle, BIN_QTY cycles total.
- pre[b] = min(pre[b-1] + cnt[b], LEDS), with pre[-1]=0. The sum is computed CW+1 bits wide, then saturated.
- Then go to STREAM with pixel index k=0.

STREAM:
- Pixel k uses slot s:
  - normal: s = (k + offset) mod LEDS
  - reverse: s = (LEDS-1-k + offset) mod LEDS
  - Modulo is done by a single conditional subtract; no divider.
- Colour is rgb[b] for the lowest b with s < pre[b]. If s ≥ pre[BIN_QTY-1] the colour is 0 (black padding).
- Bins with count 0 never appear.
- out_rgb and out_last are registered. The first out_valid is asserted 1+BIN_QTY+1 cycles after the accept edge.
- Hold rule: while out_valid & !out_ready, out_rgb, out_last and k hold stable.
- On each handshake, k increments. A new pixel is presented in the following cycle, so full throughput is 1 pixel per cycle when out_ready=1.
- out_last=1 exactly when k=LEDS-1.
- On the last handshake:
  - out_valid drops.
  - frame_done pulses next cycle.
  - If the latched rotate flag is set: offset ← (offset + ROT_STEP) mod LEDS.
  - Return to IDLE; in_ready=1 in the same cycle as the frame_done pulse.

Boundaries:
- Sum of counts > LEDS: truncated by saturation; trailing bins are dropped.
- Sum of counts < LEDS: remaining slots are black.
- All counts zero: whole frame is black.
- Offset wraps at LEDS.
- in_valid during PREFIX or STREAM is ignored (not latched); the upstream must hold it.
- rst mid-frame: returns to IDLE immediately, out_valid=0 next cycle, offset=0, no frame_done.

Decomposition:
- Shared package CCHW gains:
  - typedef rgb_t (24-bit, R in [23:16], G in [15:8], B in [7:0])
  - enum lls_state_t {IDLE, PREFIX, STREAM}
- One natural sub-module: slot_bin_lookup. It is combinational: takes slot s and the pre[] array, and returns the bin index plus a pad flag via priority compare. It is instantiated once.

Test Plan:
Parameters for all scenarios: LEDS=8, BIN_QTY=3, ROT_STEP=1; rgb = {A=0xFF0000, B=0x00FF00, C=0x0000FF}; out_ready=1 unless stated.

1. Counts {3,2,3}, normal, no rotate → stream A,A,A,B,B,C,C,C. out_last on the 8th pixel. First out_valid 5 cycles after accept. frame_done 1 cycle after the last pixel.
2. Counts {2,1,1} → A,A,B,C followed by 4 pixels of 0x000000. Counts {6,6,6} → 6×A, 2×B, no C.
3. Counts {3,2,3}, reverse → C,C,C,B,B,A,A,A.
4. Rotate on, same frame sent 3 times → frame 2 starts A,A,B,B,C,C,C,A. Frame 3 starts A,B,B,C,C,C,A,A. Offset wraps to 0 after 8 frames.
5. out_ready toggled 1,0,0,1,… mid-stream → no pixel is lost or duplicated; out_rgb is stable while stalled. in_valid asserted during STREAM is not accepted until in_ready=1.
6. rst asserted at the 4th pixel → out_valid=0 next cycle, in_ready=1, no frame_done. The next frame starts at offset 0.
